multi_cycle_cu: RTL and testbench

- Multi-cycle control unit for the MIPS datapath: Moore FSM sequencing fetch, decode, execute, memory and write-back over several clocks per instruction.
- Sits beside the multi-cycle datapath (shared memory, IR, MDR, A/B, ALUOut registers).
- Drives all register enables and mux selects; supports a memory wait handshake.
- Instruction set: R-type, addi, slti, lw, sw, j, jal, jr, beq.

---
 rtl/mcu_pkg.sv | 74 +++++++
 rtl/alu_op_decoder.sv | 32 +++
 rtl/multi_cycle_cu.sv | 191 +++++++++++++++++++
 tb/tb_multi_cycle_cu.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: field widths,
// opcode/func constants, FSM states, ALU codes and datapath mux encodings.
package mcu_pkg;

    localparam int OPC_W = 6;
    localparam int ST_W  = 4;

    localparam logic [OPC_W-1:0] OPC_R    = 6'b000000;
    localparam logic [OPC_W-1:0] OPC_ADDI = 6'b001000;
    localparam logic [OPC_W-1:0] OPC_SLTI = 6'b001010;
    localparam logic [OPC_W-1:0] OPC_LW   = 6'b100011;
    localparam logic [OPC_W-1:0] OPC_SW   = 6'b101011;
    localparam logic [OPC_W-1:0] OPC_J    = 6'b000010;
    localparam logic [OPC_W-1:0] OPC_JAL  = 6'b000011;
    localparam logic [OPC_W-1:0] OPC_JR   = 6'b000111;
    localparam logic [OPC_W-1:0] OPC_BEQ  = 6'b000100;

    localparam logic [OPC_W-1:0] FUNC_ADD = 6'b100000;
    localparam logic [OPC_W-1:0] FUNC_SUB = 6'b100010;
    localparam logic [OPC_W-1:0] FUNC_AND = 6'b100100;
    localparam logic [OPC_W-1:0] FUNC_OR  = 6'b100101;
    localparam logic [OPC_W-1:0] FUNC_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_A      = 2'b11;

    typedef enum logic [1:0] {
        ALUM_ADD  = 2'b00,
        ALUM_SUB  = 2'b01,
        ALUM_FUNC = 2'b10,
        ALUM_SLT  = 2'b11
    } alu_mode_e;

    typedef enum logic [ST_W-1:0] {
        ST_RST      = 4'd0,
        ST_IF       = 4'd1,
        ST_ID       = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_LW   = 4'd4,
        ST_WB_LW    = 4'd5,
        ST_MEM_SW   = 4'd6,
        ST_EX_R     = 4'd7,
        ST_EX_ADDI  = 4'd8,
        ST_EX_SLTI  = 4'd9,
        ST_WB_R     = 4'd10,
        ST_WB_I     = 4'd11,
        ST_BEQ      = 4'd12,
        ST_J        = 4'd13,
        ST_JAL      = 4'd14,
        ST_JR       = 4'd15
    } state_e;

endpackage

// File: rtl/alu_op_decoder.sv
// Translates the FSM's coarse ALU mode (and the R-type func field) into the
// 3-bit ALU_control code driven to the datapath ALU.
module alu_op_decoder
    import mcu_pkg::*;
(
    input  alu_mode_e        mode_i,
    input  logic [OPC_W-1:0] func_i,
    output logic [2:0]       alu_control_o
);

    // Unknown func codes fall back to add so a stray R-type cannot wedge the ALU.
    always_comb begin
        alu_control_o = ALU_ADD;
        case (mode_i)
            ALUM_ADD: alu_control_o = ALU_ADD;
            ALUM_SUB: alu_control_o = ALU_SUB;
            ALUM_SLT: alu_control_o = ALU_SLT;
            ALUM_FUNC: begin
                case (func_i)
                    FUNC_ADD: alu_control_o = ALU_ADD;
                    FUNC_SUB: alu_control_o = ALU_SUB;
                    FUNC_AND: alu_control_o = ALU_AND;
                    FUNC_OR:  alu_control_o = ALU_OR;
                    FUNC_SLT: alu_control_o = ALU_SLT;
                    default:  alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multi_cycle_cu.sv
// Moore control FSM for the multi-cycle MIPS datapath. Outputs are a
// combinational decode of state, qualified by mem_ready in IF and zero in pc_en.
module multi_cycle_cu
    import mcu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opc,
    input  logic [OPC_W-1:0] func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             IorD,
    output logic             mem_read,
    output logic             mem_write,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemToReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic [2:0]       ALU_control,
    output logic             instr_done
);

    state_e    state_q, state_d;
    alu_mode_e alu_mode_s;
    logic      pc_write_s;
    logic      pc_write_cond_s;

    alu_op_decoder u_alu_op_decoder (
        .mode_i        (alu_mode_s),
        .func_i        (func),
        .alu_control_o (ALU_control)
    );

    // State register; rst is active-low and asynchronous.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; every strobe defaults low.
    always_comb begin
        state_d         = state_q;
        alu_mode_s      = ALUM_ADD;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        IorD            = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        IRWrite         = 1'b0;
        RegWrite        = 1'b0;
        RegDst          = REGDST_RT;
        MemToReg        = M2R_ALUOUT;
        ALUSrcA         = 1'b0;
        ALUSrcB         = SRCB_B;
        PCSrc           = PCSRC_ALU;
        instr_done      = 1'b0;
        case (state_q)
            ST_RST: state_d = ST_IF;
            ST_IF: begin
                mem_read = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    pc_write_s = 1'b1;
                    state_d    = ST_ID;
                end else begin
                    state_d = ST_IF;
                end
            end
            ST_ID: begin
                // Branch target is precomputed into ALUOut here for BEQ.
                ALUSrcB = SRCB_IMM_SH;
                case (opc)
                    OPC_LW, OPC_SW: state_d = ST_MEM_ADDR;
                    OPC_R:          state_d = ST_EX_R;
                    OPC_ADDI:       state_d = ST_EX_ADDI;
                    OPC_SLTI:       state_d = ST_EX_SLTI;
                    OPC_BEQ:        state_d = ST_BEQ;
                    OPC_J:          state_d = ST_J;
                    OPC_JAL:        state_d = ST_JAL;
                    OPC_JR:         state_d = ST_JR;
                    default: begin
                        instr_done = 1'b1;
                        state_d    = ST_IF;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                if (opc == OPC_SW) begin
                    state_d = ST_MEM_SW;
                end else begin
                    state_d = ST_MEM_LW;
                end
            end
            ST_MEM_LW: begin
                mem_read = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    state_d = ST_WB_LW;
                end else begin
                    state_d = ST_MEM_LW;
                end
            end
            ST_WB_LW: begin
                RegWrite   = 1'b1;
                MemToReg   = M2R_MDR;
                instr_done = 1'b1;
                state_d    = ST_IF;
            end
            ST_MEM_SW: begin
                mem_write = 1'b1;
                IorD      = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = ST_IF;
                end else begin
                    state_d = ST_MEM_SW;
                end
            end
            ST_EX_R: begin
                ALUSrcA    = 1'b1;
                alu_mode_s = ALUM_FUNC;
                state_d    = ST_WB_R;
            end
            ST_EX_ADDI: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = ST_WB_I;
            end
            ST_EX_SLTI: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                alu_mode_s = ALUM_SLT;
                state_d    = ST_WB_I;
            end
            ST_WB_R: begin
                RegWrite   = 1'b1;
                RegDst     = REGDST_RD;
                instr_done = 1'b1;
                state_d    = ST_IF;
            end
            ST_WB_I: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_IF;
            end
            ST_BEQ: begin
                ALUSrcA         = 1'b1;
                alu_mode_s      = ALUM_SUB;
                pc_write_cond_s = 1'b1;
                PCSrc           = PCSRC_ALUOUT;
                instr_done      = 1'b1;
                state_d         = ST_IF;
            end
            ST_J: begin
                pc_write_s = 1'b1;
                PCSrc      = PCSRC_JUMP;
                instr_done = 1'b1;
                state_d    = ST_IF;
            end
            ST_JAL: begin
                // PC already holds PC+4 from IF, so the link value is ready.
                pc_write_s = 1'b1;
                PCSrc      = PCSRC_JUMP;
                RegWrite   = 1'b1;
                RegDst     = REGDST_RA;
                MemToReg   = M2R_PC;
                instr_done = 1'b1;
                state_d    = ST_IF;
            end
            ST_JR: begin
                pc_write_s = 1'b1;
                PCSrc      = PCSRC_A;
                instr_done = 1'b1;
                state_d    = ST_IF;
            end
            default: state_d = ST_RST;
        endcase
        pc_en = pc_write_s | (pc_write_cond_s & zero);
    end

endmodule

// File: tb/tb_multi_cycle_cu.sv
// Directed bench for multi_cycle_cu: walks each instruction class cycle by
// cycle and compares the packed output vector against hand-built expectations.
module tb_multi_cycle_cu;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_ctl;
        logic       done;
    } outs_t;

    function outs_t mk(input logic pe, input logic io, input logic mr, input logic mw,
                       input logic irw, input logic rw, input logic [1:0] rd,
                       input logic [1:0] m2r, input logic sa, input logic [1:0] sb,
                       input logic [1:0] ps, input logic [2:0] alu, input logic dn);
        mk = {pe, io, mr, mw, irw, rw, rd, m2r, sa, sb, ps, alu, dn};
    endfunction

    localparam outs_t E_RST  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,3'b010,1'b0);
    localparam outs_t E_IF   = mk(1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,2'b01,2'b00,3'b010,1'b0);
    localparam outs_t E_IFW  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,2'b00,3'b010,1'b0);
    localparam outs_t E_ID   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b11,2'b00,3'b010,1'b0);
    localparam outs_t E_IDX  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b11,2'b00,3'b010,1'b1);
    localparam outs_t E_MA   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,2'b00,3'b010,1'b0);
    localparam outs_t E_LW   = mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,3'b010,1'b0);
    localparam outs_t E_WBLW = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b0,2'b00,2'b00,3'b010,1'b1);
    localparam outs_t E_SWW  = mk(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,3'b010,1'b0);
    localparam outs_t E_SW   = mk(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,3'b010,1'b1);
    localparam outs_t E_WBR  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,1'b0,2'b00,2'b00,3'b010,1'b1);
    localparam outs_t E_EXI  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,2'b00,3'b010,1'b0);
    localparam outs_t E_EXS  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,2'b00,3'b111,1'b0);
    localparam outs_t E_WBI  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,2'b00,2'b00,3'b010,1'b1);
    localparam outs_t E_J    = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b10,3'b010,1'b1);
    localparam outs_t E_JAL  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b10,1'b0,2'b00,2'b10,3'b010,1'b1);
    localparam outs_t E_JR   = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b11,3'b010,1'b1);

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opc;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, IorD, mem_read, mem_write, IRWrite, RegWrite, ALUSrcA, instr_done;
    logic [1:0] RegDst, MemToReg, ALUSrcB, PCSrc;
    logic [2:0] ALU_control;
    outs_t      outs;
    int         checks = 0;
    int         errors = 0;

    assign outs = {pc_en, IorD, mem_read, mem_write, IRWrite, RegWrite, RegDst, MemToReg,
                   ALUSrcA, ALUSrcB, PCSrc, ALU_control, instr_done};

    always #5 clk = ~clk;

    multi_cycle_cu dut (
        .clk(clk), .rst(rst), .opc(opc), .func(func), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .IorD(IorD), .mem_read(mem_read), .mem_write(mem_write),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALU_control(ALU_control),
        .instr_done(instr_done)
    );

    task automatic test_reset();
        rst = 1'b0; opc = 6'b000000; func = 6'b100000; zero = 1'b0; mem_ready = 1'b1;
        #2;
        checks++;
        if (outs !== E_RST) begin errors++; $display("FAIL reset_hold: got %h expected %h", outs, E_RST); end
        @(posedge clk); #1;
        checks++;
        if (outs !== E_RST) begin errors++; $display("FAIL reset_edge: got %h expected %h", outs, E_RST); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        logic [5:0] fn [6];
        logic [2:0] ac [6];
        outs_t      seq [4];
        fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
        ac = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
        opc = 6'b000000;
        for (int k = 0; k < 6; k++) begin
            func = fn[k];
            seq = '{E_IF, E_ID, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,2'b00,ac[k],1'b0), E_WBR};
            for (int i = 0; i < 4; i++) begin
                mem_ready = 1'b1; #1;
                checks++;
                if (outs !== seq[i]) begin errors++; $display("FAIL rtype func=%b cycle %0d: got %h expected %h", func, i, outs, seq[i]); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_addi_slti();
        outs_t seq [4];
        for (int k = 0; k < 2; k++) begin
            opc = (k == 0) ? 6'b001000 : 6'b001010;
            seq = '{E_IF, E_ID, (k == 0) ? E_EXI : E_EXS, E_WBI};
            for (int i = 0; i < 4; i++) begin
                mem_ready = 1'b1; #1;
                checks++;
                if (outs !== seq[i]) begin errors++; $display("FAIL imm opc=%b cycle %0d: got %h expected %h", opc, i, outs, seq[i]); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_lw_wait();
        outs_t seq [7];
        logic  rdy [7];
        seq = '{E_IF, E_ID, E_MA, E_LW, E_LW, E_LW, E_WBLW};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        opc = 6'b100011;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i]; #1;
            checks++;
            if (outs !== seq[i]) begin errors++; $display("FAIL lw_wait cycle %0d: got %h expected %h", i, outs, seq[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_wait();
        outs_t seq [5];
        logic  rdy [5];
        seq = '{E_IF, E_ID, E_MA, E_SWW, E_SW};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        opc = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i]; #1;
            checks++;
            if (outs !== seq[i]) begin errors++; $display("FAIL sw_wait cycle %0d: got %h expected %h", i, outs, seq[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq();
        outs_t seq [3];
        opc = 6'b000100;
        for (int k = 0; k < 2; k++) begin
            zero = (k == 0);
            seq = '{E_IF, E_ID, mk(zero,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,2'b01,3'b110,1'b1)};
            for (int i = 0; i < 3; i++) begin
                mem_ready = 1'b1; #1;
                checks++;
                if (outs !== seq[i]) begin errors++; $display("FAIL beq zero=%b cycle %0d: got %h expected %h", zero, i, outs, seq[i]); end
                @(posedge clk); #1;
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jumps();
        logic [5:0] ops [3];
        outs_t      fin [3];
        outs_t      seq [3];
        ops = '{6'b000010, 6'b000011, 6'b000111};
        fin = '{E_J, E_JAL, E_JR};
        for (int k = 0; k < 3; k++) begin
            opc = ops[k];
            seq = '{E_IF, E_ID, fin[k]};
            for (int i = 0; i < 3; i++) begin
                mem_ready = 1'b1; #1;
                checks++;
                if (outs !== seq[i]) begin errors++; $display("FAIL jump opc=%b cycle %0d: got %h expected %h", opc, i, outs, seq[i]); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_undef_fetch_wait();
        outs_t seq [6];
        logic  rdy [6];
        seq = '{E_IFW, E_IFW, E_IFW, E_IF, E_IDX, E_IF};
        rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        opc = 6'b111111;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy[i]; #1;
            checks++;
            if (outs !== seq[i]) begin errors++; $display("FAIL undef_fetch cycle %0d: got %h expected %h", i, outs, seq[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        outs_t seq [2];
        seq = '{E_ID, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,2'b00,3'b110,1'b0)};
        opc = 6'b000000; func = 6'b100010;
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'b1; #1;
            checks++;
            if (outs !== seq[i]) begin errors++; $display("FAIL reset_mid pre cycle %0d: got %h expected %h", i, outs, seq[i]); end
            if (i == 0) begin @(posedge clk); #1; end
        end
        rst = 1'b0; #1;
        checks++;
        if (outs !== E_RST) begin errors++; $display("FAIL reset_mid async: got %h expected %h", outs, E_RST); end
        @(posedge clk); #1;
        checks++;
        if (outs !== E_RST) begin errors++; $display("FAIL reset_mid held: got %h expected %h", outs, E_RST); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (outs !== E_IF) begin errors++; $display("FAIL reset_mid release: got %h expected %h", outs, E_IF); end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rtype();
        test_addi_slti();
        test_lw_wait();
        test_sw_wait();
        test_beq();
        test_jumps();
        test_undef_fetch_wait();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
